// File: rtl/pcie_tlp_req_gen.sv
// pcie_tlp_req_gen: PCIe memory request header generator for the DMA path.
// Byte-granular read/write commands are split at MPS (writes) or MRRS (reads)
// boundaries. Each piece gets a 3DW/4DW MRd/MWr header with its DW length and
// byte enables. Read tags come from an internal busy map that completions refill.
// Optional feature macro: PCIE_TLP_4DW_EN enables 4DW headers for addresses
// above 4 GB. Without it only 3DW headers are built and cmd_addr[63:32] is ignored.
// ADDR_WIDTH is expected to be in the range 14..64.
module pcie_tlp_req_gen #(
  parameter int ADDR_WIDTH        = 64,
  parameter int MAX_PAYLOAD_SIZE  = 128,
  parameter int MAX_READ_REQ_SIZE = 512,
  parameter int TAG_COUNT         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           cfg_bdf,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [12:0]           cmd_len,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [127:0]          hdr_data,
  output logic                  hdr_4dw,
  output logic [9:0]            hdr_len_dw,
  input  logic                  tag_free_valid,
  input  logic [7:0]            tag_free,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t                state;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [13:0]           rem;
  logic [13:0]           chunk_q;
  logic [TAG_COUNT-1:0]  tag_busy;

  logic [63:0] addr_ext;
  logic [13:0] limit;
  logic [13:0] offset;
  logic [13:0] room;
  logic [13:0] chunk;
  logic [13:0] end_byte;
  logic [13:0] len_dw;
  logic [3:0]  first_be;
  logic [3:0]  last_be;
  logic        is_4dw;
  logic [7:0]  free_tag;
  logic        tag_found;
  logic [7:0]  hdr_tag;
  logic        can_go;
  logic        alloc;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic [31:0] dw3;

  // Chunk size, DW length and byte enables for the piece at the current address
  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_WIDTH-1:0] = addr;
    limit    = wr ? 14'(MAX_PAYLOAD_SIZE) : 14'(MAX_READ_REQ_SIZE);
    offset   = addr_ext[13:0] & (limit - 14'd1);
    room     = limit - offset;
    chunk    = (rem < room) ? rem : room;
    // Index of the last byte counted from the DW-aligned start; chunk is never 0 here
    end_byte = {12'd0, addr_ext[1:0]} + chunk - 14'd1;
    len_dw   = (end_byte >> 2) + 14'd1;
    first_be = '0;
    last_be  = '0;
    for (int i = 0; i < 4; i++) begin
      first_be[i] = (2'(i) >= addr_ext[1:0]) && (14'(i) <= end_byte);
      last_be[i]  = (len_dw != 14'd1) && (2'(i) <= end_byte[1:0]);
    end
  end

  // Lowest free tag in the pool (scan from the top so the lowest index wins)
  always_comb begin
    free_tag  = '0;
    tag_found = 1'b0;
    for (int i = TAG_COUNT - 1; i >= 0; i--) begin
      if (!tag_busy[i]) begin
        tag_found = 1'b1;
        free_tag  = 8'(i);
      end
    end
  end

  // Header words; DW layout keeps byte 0 in the MSBs of each 32-bit word
  always_comb begin
`ifdef PCIE_TLP_4DW_EN
    is_4dw  = |addr_ext[63:32];
`else
    is_4dw  = 1'b0;
`endif
    hdr_tag = wr ? 8'd0 : free_tag;
    can_go  = wr || tag_found;
    alloc   = (state == CALC) && !wr && tag_found;
    dw0     = {1'b0, wr, is_4dw, 5'b00000, 14'd0, len_dw[9:0]};
    dw1     = {cfg_bdf, hdr_tag, last_be, first_be};
    dw2     = is_4dw ? addr_ext[63:32] : {addr_ext[31:2], 2'b00};
    dw3     = is_4dw ? {addr_ext[31:2], 2'b00} : 32'd0;
  end

  // Control FSM with registered handshake and header outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      hdr_valid  <= 1'b0;
      hdr_data   <= '0;
      hdr_4dw    <= 1'b0;
      hdr_len_dw <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && (cmd_len != 13'd0)) begin
            state     <= CALC;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CALC: begin
          if (can_go) begin
            state      <= EMIT;
            hdr_valid  <= 1'b1;
            hdr_data   <= {dw3, dw2, dw1, dw0};
            hdr_4dw    <= is_4dw;
            hdr_len_dw <= len_dw[9:0];
          end
        end
        EMIT: begin
          if (hdr_ready) begin
            hdr_valid <= 1'b0;
            if (rem == chunk_q) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command datapath: address/remaining count, advanced after each header handshake
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      wr   <= cmd_write;
      addr <= cmd_addr;
      rem  <= {1'b0, cmd_len};
    end else if (state == CALC && can_go) begin
      chunk_q <= chunk;
    end else if (state == EMIT && hdr_ready) begin
      addr <= addr + ADDR_WIDTH'(chunk_q);
      rem  <= rem - chunk_q;
    end
  end

  // Tag busy map; a tag released this cycle is only visible to allocation next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_busy <= '0;
    end else begin
      for (int i = 0; i < TAG_COUNT; i++) begin
        if (alloc && (free_tag == 8'(i))) begin
          tag_busy[i] <= 1'b1;
        end else if (tag_free_valid && (tag_free == 8'(i))) begin
          tag_busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/pcie_tlp_req_gen.md
# pcie_tlp_req_gen

Parametrised PCIe memory-request header generator for the DMA path. It accepts byte-granular read/write commands and splits each one at Max Payload Size (writes) or Max Read Request Size (reads) boundaries. For each piece it emits a 3DW or 4DW TLP header with computed length and byte enables. Read tags come from an internal pool that the completion path refills.

## Interface
- ADDR_WIDTH, 64: command address width.
- MAX_PAYLOAD_SIZE, 128: write split limit in bytes; power of two, 128–4096.
- MAX_READ_REQ_SIZE, 512: read split limit in bytes; power of two, 128–4096.
- TAG_COUNT, 32: read tags in the pool; 1–256.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_bdf  in  16  requester ID; sampled when a header is loaded.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = Memory Write, 0 = Memory Read.
- cmd_addr  in  ADDR_WIDTH  byte start address.
- cmd_len  in  13  byte count, 0–4096.
- hdr_valid / hdr_ready  out/in  1  header handshake.
- hdr_data  out  128  DW0 in [31:0] through DW3 in [127:96]. Byte 0 of each DW is in its MSBs. DW3 is 0 for 3DW headers.
- hdr_4dw  out  1  header is 4DW.
- hdr_len_dw  out  10  payload/request length in DW; 0 encodes 1024.
- tag_free_valid  in  1  completion path releases a tag.
- tag_free  in  8  tag being released.
- busy  out  1  a command is in progress.

## Operation
- States: IDLE, CALC, EMIT.
- IDLE: cmd_ready=1.
  - On handshake, latch write, addr, rem=cmd_len and go to CALC.
  - If cmd_len=0, the command is dropped and the block stays in IDLE; no header.
- CALC: compute the chunk and build the header.
  - chunk = min(rem, LIMIT − (addr mod LIMIT)), where LIMIT is the split limit for the command direction.
  - Because LIMIT divides 4 KB, no chunk crosses a 4 KB boundary.
  - Length in DW = ceil((addr[1:0]+chunk)/4).
  - first_be covers bytes addr[1:0]..min(3, addr[1:0]+chunk−1).
  - last_be = 0000 when the length is 1 DW; otherwise it covers bytes 0..((addr+chunk−1) mod 4).
  - Use 14-bit intermediates; no truncation.
- Header format:
  - fmt = {0, write, 4dw}; type = 00000.
  - TC, attr, TH, TD, EP, AT are all 0.
  - 4DW when addr[63:32]≠0: DW2=addr[63:32], DW3={addr[31:2],00}. Otherwise 3DW: DW2={addr[31:2],00}.
- Tag allocation in CALC:
  - A read takes the lowest free tag. If none is free, stay in CALC (hdr_valid=0) until one is released.
  - A write uses tag 0 and does not touch the pool.
- EMIT: hdr_valid=1 and all header outputs stay stable until hdr_ready.
  - On handshake: addr+=chunk, rem−=chunk, then CALC if rem≠0, else IDLE.
- Tag pool: TAG_COUNT-bit busy map.
  - tag_free for a tag that is not busy, or ≥TAG_COUNT, is ignored.
  - A release and an allocation in the same cycle: the released tag becomes allocatable the next cycle.
- busy=1 in CALC and EMIT.

## Timing
- Reset values: cmd_ready=1 (IDLE after reset); hdr_valid=0; hdr_data=0; hdr_4dw=0; hdr_len_dw=0; busy=0; all tags free.
- Reset in any state aborts the command; no partial header is emitted afterwards.
- Latency:
  - Command accepted in cycle N gives hdr_valid in N+2 when no stall.
  - Back-to-back split headers come one every 2 cycles with hdr_ready held high.
- cmd_ready is 0 from the cycle after acceptance until the last header handshake.
- The next command can be accepted in the cycle after the last handshake.

## Configuration
- PCIE_TLP_4DW_EN:
  - Defined: behaviour as above (3DW/4DW selection, 64-bit addressing).
  - Undefined: cmd_addr[63:32] is ignored, hdr_4dw is tied 0, DW3 is always 0, and only the 3DW path is synthesised.

## Test plan
- Write, addr 0x1000_0004, len 8 → one header: fmt 010, length 2, first_be 1111, last_be 1111, tag 0, DW2 0x1000_0004.
- Write, addr 0x70, len 64, MPS 128 → two headers:
  - addr 0x70, length 4;
  - addr 0x80, length 12.
- Read, addr 0x1_0000_0002, len 2 (macro defined) → fmt 001, length 1, first_be 1100, last_be 0000, DW2 0x1, DW3 0x0000_0000; tag 0. Rerun without the macro → fmt 000, 3DW, DW2 0x0000_0000.
- TAG_COUNT=4, five 64 B reads with no releases:
  - tags 0,1,2,3 are issued; the fifth stalls with hdr_valid=0;
  - pulse tag_free=2 → fifth header appears with tag 2.
- Hold hdr_ready=0 for 10 cycles in EMIT → hdr_data stable. Then assert rst for one cycle → next cycle hdr_valid=0, cmd_ready=1, busy=0.
- cmd_len=0 → no header; cmd_ready stays 1; the next valid command is processed normally.
